// File: rtl/prog_loader.sv
// Byte-stream program loader: frames LEN, words and an XOR checksum into
// instruction memory and holds the CPU in reset until a load succeeds.
module prog_loader #(
    parameter int ADDR_W = 8,
    parameter int WORD_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        ST_IDLE, ST_LEN_HI, ST_LEN_LO, ST_DATA_HI,
        ST_DATA_LO, ST_CHECK, ST_DONE, ST_ERROR
    } state_t;

    localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

    state_t            state_q, state_d;
    logic [7:0]        xor_q, xor_d;
    logic [15:0]       len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic              xfer;
    logic [15:0]       n_len;

    assign in_ready = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                      (state_q == ST_DATA_HI) || (state_q == ST_DATA_LO) ||
                      (state_q == ST_CHECK);
    assign xfer      = in_valid && in_ready;
    assign n_len     = {len_q[15:8], in_data};
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == ST_DONE);
    assign error     = (state_q == ST_ERROR);
    assign cpu_hold  = (state_q != ST_DONE);

    always_comb begin
        state_d = state_q;
        xor_d   = xor_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    xor_d   = 8'h00;
                    cnt_d   = '0;
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = in_data;
                    xor_d       = xor_q ^ in_data;
                    state_d     = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = in_data;
                    xor_d      = xor_q ^ in_data;
                    if (n_len == 16'd0)
                        state_d = ST_CHECK;
                    else if ({1'b0, n_len} > DEPTH)
                        state_d = ST_ERROR;
                    else
                        state_d = ST_DATA_HI;
                end
            end
            ST_DATA_HI: begin
                if (xfer) begin
                    hi_d    = in_data;
                    xor_d   = xor_q ^ in_data;
                    state_d = ST_DATA_LO;
                end
            end
            ST_DATA_LO: begin
                if (xfer) begin
                    we_d    = 1'b1;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    wdata_d = {hi_q, in_data};
                    xor_d   = xor_q ^ in_data;
                    // counter is one bit wider so a full-depth load ends cleanly
                    if (17'(cnt_q) == {1'b0, len_q} - 17'd1) begin
                        state_d = ST_CHECK;
                    end else begin
                        cnt_d   = cnt_q + 1'b1;
                        state_d = ST_DATA_HI;
                    end
                end
            end
            ST_CHECK: begin
                if (xfer)
                    state_d = (in_data == xor_q) ? ST_DONE : ST_ERROR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            xor_q   <= 8'h00;
            len_q   <= 16'h0000;
            cnt_q   <= '0;
            hi_q    <= 8'h00;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            xor_q   <= xor_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: good, bad-checksum, empty, oversize,
// throttled and reset-abort frames against hand-computed results.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;

    int vectors = 0;
    int fails   = 0;

    logic [7:0]  wa[$];
    logic [15:0] wd[$];

    prog_loader #(.ADDR_W(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        bit ok;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = b;
            if (in_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        chk({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_error"}, 32'(error), 32'd0);
    endtask

    task automatic check_two_writes(input string tag);
        chk({tag, "_nwr"}, 32'(wa.size()), 32'd2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, 32'(wa[0]), 32'h00);
            chk({tag, "_d0"}, 32'(wd[0]), 32'h1234);
            chk({tag, "_a1"}, 32'(wa[1]), 32'h01);
            chk({tag, "_d1"}, 32'(wd[1]), 32'hABCD);
        end
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        #2;
        check_reset_outputs("rst");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_hold", 32'(cpu_hold), 32'd1);
        chk("post_rst_rdy", 32'(in_ready), 32'd0);

        // good load
        wa.delete(); wd.delete();
        pulse_start();
        chk("lenhi_rdy", 32'(in_ready), 32'd1);
        chk("load_hold", 32'(cpu_hold), 32'd1);
        send(8'h00, 0); send(8'h02, 0);
        send(8'h12, 0); send(8'h34, 0);
        send(8'hAB, 0); send(8'hCD, 0);
        send(8'h42, 0);
        idle();
        chk("good_done", 32'(done), 32'd1);
        chk("good_err", 32'(error), 32'd0);
        chk("good_hold", 32'(cpu_hold), 32'd0);
        chk("good_rdy", 32'(in_ready), 32'd0);
        check_two_writes("good");

        // bad checksum
        wa.delete(); wd.delete();
        pulse_start();
        chk("restart_hold", 32'(cpu_hold), 32'd1);
        chk("restart_done", 32'(done), 32'd0);
        send(8'h00, 0); send(8'h02, 0);
        send(8'h12, 0); send(8'h34, 0);
        send(8'hAB, 0); send(8'hCD, 0);
        send(8'h43, 0);
        idle();
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_err", 32'(error), 32'd1);
        chk("bad_hold", 32'(cpu_hold), 32'd1);
        check_two_writes("bad");

        // empty program
        wa.delete(); wd.delete();
        pulse_start();
        chk("empty_err_clr", 32'(error), 32'd0);
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        idle();
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_nwr", 32'(wa.size()), 32'd0);

        // oversize: 257 words on a 256-deep memory
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h01, 0); send(8'h01, 0);
        idle();
        chk("over_err", 32'(error), 32'd1);
        chk("over_done", 32'(done), 32'd0);
        chk("over_rdy", 32'(in_ready), 32'd0);
        chk("over_hold", 32'(cpu_hold), 32'd1);
        repeat (3) @(negedge clk);
        chk("over_nwr", 32'(wa.size()), 32'd0);
        pulse_start();
        send(8'h00, 0); send(8'h02, 0);
        send(8'h12, 0); send(8'h34, 0);
        send(8'hAB, 0); send(8'hCD, 0);
        send(8'h42, 0);
        idle();
        chk("over_then_done", 32'(done), 32'd1);
        check_two_writes("over_then");

        // throttled with a stray start mid-frame
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h00, $urandom_range(0, 3));
        send(8'h02, $urandom_range(0, 3));
        send(8'h12, $urandom_range(0, 3));
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        send(8'h34, $urandom_range(0, 3));
        send(8'hAB, $urandom_range(0, 3));
        send(8'hCD, $urandom_range(0, 3));
        send(8'h42, $urandom_range(0, 3));
        idle();
        chk("thr_done", 32'(done), 32'd1);
        chk("thr_err", 32'(error), 32'd0);
        chk("thr_hold", 32'(cpu_hold), 32'd0);
        check_two_writes("thr");

        // reset mid-frame, right after the 0x12 byte
        wa.delete(); wd.delete();
        pulse_start();
        send(8'h00, 0); send(8'h02, 0); send(8'h12, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h34;
        #1;
        rst = 1'b0;
        #1;
        check_reset_outputs("abort");
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("abort_rdy", 32'(in_ready), 32'd0);
        chk("abort_hold", 32'(cpu_hold), 32'd1);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_nwr", 32'(wa.size()), 32'd0);
        in_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8, instruction memory address width; depth = 2^ADDR_W words.
REQ-002 Parameter WORD_W, fixed at 16, instruction word width, assembled from two bytes.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR.
REQ-006 in_data  input  8  incoming program byte.
REQ-007 in_valid  input  1  in_data is valid this cycle.
REQ-008 in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
REQ-009 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-010 mem_addr  output  ADDR_W  write address.
REQ-011 mem_wdata  output  16  write data, {high byte, low byte}.
REQ-012 cpu_hold  output  1  when high, holds the stack CPU in reset.
REQ-013 done  output  1  program loaded and checksum good; level signal.
REQ-014 error  output  1  load failed; level signal.

Function
REQ-015 The byte frame SHALL be: LEN_HI, LEN_LO (N words, 16-bit), N x (word high byte, word low byte), then one CHK byte.
REQ-016 CHK SHALL equal the XOR of every preceding frame byte, including the length bytes.
REQ-017 FSM states SHALL be IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE and ERROR.
REQ-018 IDLE/DONE/ERROR + start -> LEN_HI; on that transition clear the running XOR, word counter, done and error, and set cpu_hold=1.
REQ-019 start SHALL be ignored in LEN_HI..CHECK.
REQ-020 in_ready SHALL be 1 exactly in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK; it SHALL be 0 elsewhere.
REQ-021 A state holds indefinitely while no transfer occurs; in_valid gaps do not alter state.
REQ-022 Each transfer SHALL advance exactly one state and XOR the byte into the running checksum; the CHK byte itself is excluded from the checksum.
REQ-023 After LEN_LO: N==0 -> CHECK; N > 2^ADDR_W -> ERROR (no memory writes); otherwise -> DATA_HI.
REQ-024 DATA_HI transfer latches the high byte -> DATA_LO.
REQ-025 DATA_LO transfer SHALL produce, on the next cycle, mem_we=1 for one cycle with mem_addr = word index (0-based) and mem_wdata = {hi, lo}.
REQ-026 After a DATA_LO transfer: if the word index is N-1 -> CHECK, else increment the index -> DATA_HI.
REQ-027 The word index counter SHALL be ADDR_W+1 bits wide so that N = 2^ADDR_W is loadable without wrap; mem_addr is its low ADDR_W bits.
REQ-028 CHECK transfer: byte == running XOR -> DONE (done=1, cpu_hold=0); else -> ERROR (error=1, cpu_hold stays 1).
REQ-029 done and error SHALL never be high simultaneously.
REQ-030 mem_we SHALL be 0 in every cycle other than those defined in REQ-025.

Reset
REQ-031 While rst=0: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, done=0, error=0, checksum=0, counter=0.
REQ-032 Assertion of rst mid-frame SHALL abort the load immediately and asynchronously; no mem_we pulse follows the abort; start is required after release.
REQ-033 After reset release the CPU SHALL remain held (cpu_hold=1) until a successful load.

Verification
REQ-034 Good load: start, bytes 00 02 12 34 AB CD 42 -> writes (0,0x1234) and (1,0xABCD), done=1, cpu_hold=0, error=0.
REQ-035 Bad checksum: same frame with CHK=43 -> both writes occur, then error=1, done=0, cpu_hold=1.
REQ-036 Empty program: bytes 00 00 00 -> no mem_we, done=1.
REQ-037 Oversize (ADDR_W=8): bytes 01 01 -> ERROR after LEN_LO, in_ready=0, no writes; a later start plus a valid frame -> done.
REQ-038 Throttling: in_valid toggled randomly during the REQ-034 frame -> identical writes and result; a start pulse mid-frame is ignored.
REQ-039 Reset mid-frame: rst=0 after the 12 byte of REQ-034 -> all outputs at the REQ-031 values immediately, no further writes.
